// File: rtl/display_scan.sv
// Time-multiplexed 7-segment scan controller with per-slot blanking gaps and
// frame-synchronous value loads; digit_value/digit_anode are registered (1 cycle).
module display_scan #(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 16,
  parameter int ANODE_ACT_LO = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            load,
  input  logic [5*NUM_DIGITS-1:0]         values_in,
  input  logic [NUM_DIGITS-1:0]           blank_in,
  output logic                            load_ack,
  output logic [4:0]                      digit_value,
  output logic [NUM_DIGITS-1:0]           digit_anode,
  output logic [$clog2(NUM_DIGITS)-1:0]   digit_idx
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam bit ACT_LO = (ANODE_ACT_LO != 0);
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = {NUM_DIGITS{ACT_LO}};

  logic [CNT_W-1:0]          cnt;
  logic [5*NUM_DIGITS-1:0]   live_val;
  logic [NUM_DIGITS-1:0]     live_blank;
  logic [5*NUM_DIGITS-1:0]   staged_val;
  logic [NUM_DIGITS-1:0]     staged_blank;
  logic                      pending;

  logic                      wrap;
  logic                      commit;
  logic [CNT_W-1:0]          cnt_next;
  logic [IDX_W-1:0]          idx_next;
  logic                      show_next;
  logic [5*NUM_DIGITS-1:0]   val_src;
  logic [NUM_DIGITS-1:0]     blank_src;
  logic [4:0]                value_next;
  logic [NUM_DIGITS-1:0]     anode_on;

  always_comb begin
    wrap      = (cnt == CNT_W'(CLK_DIV - 1));
    cnt_next  = wrap ? '0 : cnt + 1'b1;
    if (!wrap)
      idx_next = digit_idx;
    else if (digit_idx == IDX_W'(NUM_DIGITS - 1))
      idx_next = '0;
    else
      idx_next = digit_idx + 1'b1;
    commit    = wrap && (digit_idx == IDX_W'(NUM_DIGITS - 1)) && pending;
    show_next = (cnt_next >= CNT_W'(BLANK_CYCLES));
    // The slot about to start must already see freshly committed data.
    val_src   = commit ? staged_val : live_val;
    blank_src = commit ? staged_blank : live_blank;
    value_next = '0;
    anode_on   = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_next == IDX_W'(i)) begin
        value_next  = val_src[5*i +: 5];
        anode_on[i] = show_next && !blank_src[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      digit_idx    <= '0;
      live_val     <= '0;
      live_blank   <= '0;
      staged_val   <= '0;
      staged_blank <= '0;
      pending      <= 1'b0;
      load_ack     <= 1'b0;
      digit_value  <= 5'd0;
      digit_anode  <= ANODE_OFF;
    end else begin
      cnt         <= cnt_next;
      digit_idx   <= idx_next;
      load_ack    <= commit;
      digit_anode <= anode_on ^ ANODE_OFF;
      if (wrap)
        digit_value <= value_next;
      if (commit) begin
        live_val   <= staged_val;
        live_blank <= staged_blank;
      end
      // A load coinciding with a commit stages for the following frame.
      if (load) begin
        staged_val   <= values_in;
        staged_blank <= blank_in;
        pending      <= 1'b1;
      end else if (commit) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_display_scan.sv
// Bench for display_scan: directed scenarios plus random loads against a frame-level model.
module tb_display_scan;

  localparam int N     = 4;
  localparam int CD    = 8;
  localparam int BL    = 2;
  localparam int FRAME = N * CD;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load = 1'b0;
  logic [19:0]   values_in = '0;
  logic [3:0]    blank_in = '0;
  logic          load_ack;
  logic [4:0]    digit_value;
  logic [3:0]    digit_anode;
  logic [1:0]    digit_idx;

  int compared = 0;
  int mismatched = 0;

  // Reference model: time since reset plus live/staged images of the display.
  int          t;
  logic [19:0] lv, sv;
  logic [3:0]  lb, sb;
  bit          pend, eack;
  int          ack_seen;

  display_scan #(.NUM_DIGITS(N), .CLK_DIV(CD), .BLANK_CYCLES(BL), .ANODE_ACT_LO(1)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .values_in(values_in), .blank_in(blank_in),
    .load_ack(load_ack), .digit_value(digit_value), .digit_anode(digit_anode),
    .digit_idx(digit_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h (t=%0d)", tag, obs, exp, t);
    end
  endtask

  task automatic model_reset();
    t = 0; lv = '0; sv = '0; lb = '0; sb = '0; pend = 0; eack = 0;
  endtask

  function automatic logic [3:0] exp_anode();
    int idx;
    logic [3:0] oh;
    idx = (t / CD) % N;
    if ((t % CD) < BL || lb[idx]) return 4'hF;
    oh = 4'b0001 << idx;
    return ~oh;
  endfunction

  task automatic check_all();
    int idx;
    idx = (t / CD) % N;
    chk("idx", 32'(digit_idx), 32'(idx));
    chk("value", 32'(digit_value), 32'(lv[idx*5 +: 5]));
    chk("anode", 32'(digit_anode), 32'(exp_anode()));
    chk("ack", 32'(load_ack), 32'(eack));
  endtask

  task automatic step(input logic ld, input logic [19:0] v, input logic [3:0] b);
    bit commit;
    load = ld; values_in = v; blank_in = b;
    @(posedge clk);
    commit = (((t + 1) % FRAME) == 0) && pend;
    eack = commit;
    if (commit) begin lv = sv; lb = sb; pend = 0; end
    if (ld) begin sv = v; sb = b; pend = 1; end
    t++;
    #1;
    if (load_ack) ack_seen++;
    check_all();
    load = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, $urandom, 4'($urandom));
  endtask

  task automatic idle_until_phase(input int ph);
    for (int i = 0; i < 2*FRAME && (t % FRAME) != ph; i++) idle(1);
  endtask

  initial begin
    model_reset();
    ack_seen = 0;
    // Reset state
    #12;
    chk("rst_anode", 32'(digit_anode), 32'h0000_000F);
    chk("rst_value", 32'(digit_value), 32'h0);
    chk("rst_ack", 32'(load_ack), 32'h0);
    chk("rst_idx", 32'(digit_idx), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_all();

    // 1: free-running scan, no loads
    idle(40);
    chk("t1_no_ack", 32'(ack_seen), 32'h0);

    // 2: mid-frame load, commit at the next frame boundary
    idle_until_phase(13);
    step(1'b1, 20'h08443, 4'b0000);
    idle(FRAME + 8);

    // 3: negative values in digits 0 and 1
    step(1'b1, {10'($urandom), 5'b10000, 5'b11111}, 4'b0000);
    idle(2*FRAME);
    idle_until_phase(1);
    chk("t3_slot0_neg", 32'(digit_value), 32'h1F);
    idle(CD);
    chk("t3_slot1_neg", 32'(digit_value), 32'h10);

    // 4: blank position 2
    step(1'b1, 20'(23'h5A5A5), 4'b0100);
    idle(2*FRAME);

    // 5a: two loads before a wrap yield a single ack, second data live
    idle_until_phase(4);
    ack_seen = 0;
    step(1'b1, 20'h11111, 4'b0000);
    idle(5);
    step(1'b1, 20'hFEDCB, 4'b0000);
    idle(FRAME);
    chk("t5_single_ack", 32'(ack_seen), 32'h1);
    chk("t5_live_B", 32'(lv), 32'hFEDCB);

    // 5b: load on the exact commit edge
    step(1'b1, 20'h2468A, 4'b0001);
    idle_until_phase(FRAME - 1);
    ack_seen = 0;
    step(1'b1, 20'h13579, 4'b1000);
    chk("t5_commit_old", 32'(load_ack), 32'h1);
    idle(FRAME);
    chk("t5_two_acks", 32'(ack_seen), 32'h2);
    idle(CD);

    // 6: reset during SHOW of slot 2 with a pending load
    idle_until_phase(1);
    step(1'b1, 20'hABCDE, 4'b0000);
    idle_until_phase(2*CD + 3);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_anode_async", 32'(digit_anode), 32'h0000_000F);
    chk("t6_idx_async", 32'(digit_idx), 32'h0);
    chk("t6_value_async", 32'(digit_value), 32'h0);
    repeat (2) @(posedge clk);
    #1 chk("t6_ack_held", 32'(load_ack), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    ack_seen = 0;
    idle(2*FRAME);
    chk("t6_no_ack", 32'(ack_seen), 32'h0);

    // Random loads over many frames
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 19) == 0)
        step(1'b1, 20'($urandom), 4'($urandom));
      else
        step(1'b0, 20'($urandom), 4'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
    $fatal(1, "timeout");
  end

endmodule
